updown_gray_counter: RTL and testbench

Parametrised WIDTH-bit up/down counter with run-time selectable binary or Gray output encoding. Adds synchronous parallel load, a clock-enable prescaler and terminal-count outputs. Replaces fixed 3-bit binary/Gray counters in lab top levels; drives display and LED logic directly. Uses a clock-enable prescaler instead of a generated divided clock.

---
 rtl/updown_gray_counter.sv | 90 +++++++++
 tb/tb_updown_gray_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_gray_counter.sv
// ---------------------------------------------------------------------------
// updown_gray_counter
//
// WIDTH-bit up/down counter with run-time selectable binary or Gray output,
// synchronous parallel load, a clock-enable prescaler and terminal-count
// flag. All state updates happen on the falling edge of CLOCK. Reset is
// asynchronous and active-low.
//
// Ports:
//   CLOCK   in   system clock (state changes on the falling edge)
//   nRESET  in   asynchronous active-low reset
//   EN      in   count enable; advances the prescaler
//   UP      in   direction: 1 up, 0 down
//   M       in   output encoding: 0 binary, 1 Gray
//   LOAD    in   synchronous parallel load, overrides EN
//   D       in   load value (binary index)
//   COUNT   out  current count in the selected encoding
//   NCOUNT  out  count after the next step in the selected encoding
//   STEP    out  registered pulse, high for the period after a counting step
//   TC      out  terminal count for the current direction
// ---------------------------------------------------------------------------
module updown_gray_counter #(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 1
) (
  input  logic             CLOCK,
  input  logic             nRESET,
  input  logic             EN,
  input  logic             UP,
  input  logic             M,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] COUNT,
  output logic [WIDTH-1:0] NCOUNT,
  output logic             STEP,
  output logic             TC
);

  // Prescaler needs at least one bit even when PRESCALE is 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] idx;
  logic [PW-1:0]    pre;
  logic             step_q;

  logic [WIDTH-1:0] idx_adj;
  logic             step_fire;

  function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] x,
                                           input logic             gray);
    enc = gray ? (x ^ (x >> 1)) : x;
  endfunction

  // Neighbouring index in the current direction; natural wrap mod 2**WIDTH.
  always_comb begin
    idx_adj = UP ? (idx + WIDTH'(1)) : (idx - WIDTH'(1));
  end

  assign step_fire = EN && (pre == PRE_LAST);

  always_ff @(negedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      idx    <= '0;
      pre    <= '0;
      step_q <= 1'b0;
    end else if (LOAD) begin
      idx    <= D;
      pre    <= '0;
      step_q <= 1'b0;
    end else if (step_fire) begin
      idx    <= idx_adj;
      pre    <= '0;
      step_q <= 1'b1;
    end else if (EN) begin
      pre    <= pre + PW'(1);
      step_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
    end
  end

  // Encoding is applied only on the output side, so toggling M never
  // disturbs the index.
  assign COUNT  = enc(idx, M);
  assign NCOUNT = enc(idx_adj, M);
  assign STEP   = step_q;
  assign TC     = UP ? (&idx) : ~(|idx);

endmodule

// File: tb/tb_updown_gray_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_gray_counter
//
// Drives two counters (PRESCALE=1 and PRESCALE=3, WIDTH=3) from shared
// inputs and compares every output with an arithmetic reference model after
// each falling edge, plus directed sequences and asynchronous-reset cases.
// ---------------------------------------------------------------------------
module tb_updown_gray_counter;
  localparam int W = 3;
  localparam int N = 8;

  logic         clk;
  logic         nreset;
  logic         en;
  logic         up;
  logic         m;
  logic         load;
  logic [W-1:0] d;

  logic [W-1:0] count_a, ncount_a, count_b, ncount_b;
  logic         step_a, tc_a, step_b, tc_b;

  int checks = 0;
  int passes = 0;

  // reference model state: index, enabled edges since last step/load, STEP
  int pres   [2] = '{1, 3};
  int m_idx  [2];
  int m_cnt  [2];
  bit m_step [2];

  updown_gray_counter #(.WIDTH(W), .PRESCALE(1)) dut_a (
    .CLOCK(clk), .nRESET(nreset), .EN(en), .UP(up), .M(m), .LOAD(load),
    .D(d), .COUNT(count_a), .NCOUNT(ncount_a), .STEP(step_a), .TC(tc_a)
  );

  updown_gray_counter #(.WIDTH(W), .PRESCALE(3)) dut_b (
    .CLOCK(clk), .nRESET(nreset), .EN(en), .UP(up), .M(m), .LOAD(load),
    .D(d), .COUNT(count_b), .NCOUNT(ncount_b), .STEP(step_b), .TC(tc_b)
  );

  // clock / reset block
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] enc(input int x, input logic gray);
    logic [W-1:0] b;
    b = W'(x % N);
    return gray ? (b ^ (b >> 1)) : b;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_step[k] = 1'b0;
    end
  endtask

  // one falling edge applied to the model with the inputs present there
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!nreset) begin
        m_idx[k] = 0; m_cnt[k] = 0; m_step[k] = 1'b0;
      end else if (load) begin
        m_idx[k] = int'(d); m_cnt[k] = 0; m_step[k] = 1'b0;
      end else if (en) begin
        m_cnt[k]++;
        if (m_cnt[k] == pres[k]) begin
          m_cnt[k]  = 0;
          m_idx[k]  = (m_idx[k] + (up ? 1 : N - 1)) % N;
          m_step[k] = 1'b1;
        end else begin
          m_step[k] = 1'b0;
        end
      end else begin
        m_step[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] c[2], nc[2];
    logic         st[2], tc[2];
    int           nxt;
    c[0] = count_a; nc[0] = ncount_a; st[0] = step_a; tc[0] = tc_a;
    c[1] = count_b; nc[1] = ncount_b; st[1] = step_b; tc[1] = tc_b;
    for (int k = 0; k < 2; k++) begin
      nxt = (m_idx[k] + (up ? 1 : N - 1)) % N;
      chk($sformatf("%s.p%0d.count", tag, pres[k]), c[k], enc(m_idx[k], m));
      chk($sformatf("%s.p%0d.ncount", tag, pres[k]), nc[k], enc(nxt, m));
      chk($sformatf("%s.p%0d.step", tag, pres[k]), {2'b0, st[k]},
          {2'b0, m_step[k]});
      chk($sformatf("%s.p%0d.tc", tag, pres[k]), {2'b0, tc[k]},
          {2'b0, (up ? (m_idx[k] == N - 1) : (m_idx[k] == 0))});
    end
  endtask

  // driver: one active (falling) edge, then check on the rising edge
  task automatic tick(input string tag);
    @(negedge clk);
    model_edge();
    @(posedge clk);
    check_all(tag);
  endtask

  // asserts reset between edges, holds it across one falling edge
  task automatic do_reset(input string tag);
    nreset = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".assert"});
    @(negedge clk);
    model_edge();
    @(posedge clk);
    check_all({tag, ".held"});
    nreset = 1'b1;
    #1;
    check_all({tag, ".release"});
  endtask

  int           seq_up_bin [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
  int           seq_up_gry [9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
  int           seq_dn_gry [8] = '{4, 5, 7, 6, 2, 3, 1, 0};
  logic [W-1:0] prev;

  initial begin
    nreset = 1'b0; en = 1'b0; up = 1'b1; m = 1'b0; load = 1'b0; d = '0;
    @(posedge clk);
    do_reset("rst0");

    // binary count up, PRESCALE=1
    en = 1'b1; up = 1'b1; m = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick("bin_up");
      chk("bin_up.seq", count_a, W'(seq_up_bin[i]));
    end

    // Gray count up: one bit per transition
    do_reset("rst1");
    m = 1'b1;
    prev = count_a;
    for (int i = 0; i < 9; i++) begin
      tick("gray_up");
      chk("gray_up.seq", count_a, W'(seq_up_gry[i]));
      chk("gray_up.onebit", W'($countones(prev ^ count_a)), W'(1));
      prev = count_a;
    end

    // Gray count down from reset
    do_reset("rst2");
    en = 1'b1; m = 1'b1; up = 1'b0;
    #1;
    chk("gray_dn.tc_reset", {2'b0, tc_a}, 3'd1);
    for (int i = 0; i < 8; i++) begin
      tick("gray_dn");
      chk("gray_dn.seq", count_a, W'(seq_dn_gry[i]));
    end

    // prescaler: steps on 3rd enabled edge; EN drop freezes pre
    up = 1'b1; m = 1'b0;
    do_reset("rst3");
    for (int i = 0; i < 4; i++) tick("pre_run");
    chk("pre.after4", count_b, W'(1));
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick("pre_hold");
    en = 1'b1;
    tick("pre_resume1");
    chk("pre.resume1", count_b, W'(1));
    tick("pre_resume2");
    chk("pre.resume2", count_b, W'(2));

    // load collides with a pending step on dut_b
    tick("pre_a");
    tick("pre_b");
    load = 1'b1; d = 3'd5; m = 1'b1;
    tick("load");
    chk("load.gray5", count_b, W'(7));
    load = 1'b0;
    m = 1'b0;
    #1;
    chk("load.bin5", count_b, W'(5));
    check_all("m_toggle");
    for (int i = 0; i < 3; i++) tick("load_restart");
    chk("load.restart", count_b, W'(6));

    // async reset while idx=6
    load = 1'b1; d = 3'd6;
    tick("load6");
    load = 1'b0;
    chk("pre_rst.idx6", count_a, W'(6));
    do_reset("rst_mid");
    chk("rst_mid.count", count_a, W'(0));
    for (int i = 0; i < 3; i++) tick("after_rst");
    chk("after_rst.first", count_b, W'(1));

    // randomized stimulus
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 9) < 8);
      up   = 1'($urandom_range(0, 1));
      m    = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 9) == 0);
      d    = W'($urandom_range(0, N - 1));
      #1;
      check_all("rnd_comb");
      tick("rnd");
      if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
